// File: rtl/ldm_stm_sequencer.sv
// Block-transfer sequencer for LDM/STM (increment-after): walks a register list one
// register per cycle, driving register-file, PC and data-memory ports, then an optional base writeback.
module ldm_stm_sequencer #(
  parameter int N_REGS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              is_load,
  input  logic              wb,
  input  logic [3:0]        rn,
  input  logic [31:0]       base,
  input  logic [N_REGS-1:0] reglist,
  output logic              rf_we,
  output logic [3:0]        rf_wa,
  output logic [31:0]       rf_wd,
  output logic [3:0]        rf_ra,
  input  logic [31:0]       rf_rd,
  output logic              pc_we,
  output logic [31:0]       pc_wd,
  output logic [31:0]       mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wd,
  input  logic [31:0]       mem_rd,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, XFER, WB, DONE} state_t;

  state_t            state, state_nxt;
  logic [N_REGS-1:0] pending, pending_nxt;
  logic [31:0]       addr, addr_nxt;
  logic              ld_q;
  logic              wb_q;   // writeback taken: wb requested and base not itself reloaded
  logic [3:0]        rn_q;
  logic [3:0]        cur;
  logic              last;

  always_comb begin
    cur = '0;
    for (int i = N_REGS - 1; i >= 0; i--) begin
      if (pending[i]) cur = 4'(i);
    end
  end

  assign last = ((pending & (pending - N_REGS'(1))) == '0);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      pending <= '0;
      addr    <= '0;
      ld_q    <= 1'b0;
      wb_q    <= 1'b0;
      rn_q    <= '0;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      addr    <= addr_nxt;
      if (state == IDLE && start) begin
        ld_q <= is_load;
        wb_q <= wb & ~(is_load & reglist[rn]);
        rn_q <= rn;
      end
    end
  end

  // NOTE: every signal gets a default before the case so no path can infer a latch.
  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    addr_nxt    = addr;
    rf_we       = 1'b0;
    rf_wa       = '0;
    rf_wd       = '0;
    rf_ra       = '0;
    pc_we       = 1'b0;
    pc_wd       = '0;
    mem_addr    = '0;
    mem_we      = 1'b0;
    mem_wd      = '0;
    busy        = 1'b0;
    done        = 1'b0;

    unique case (state)
      IDLE: begin
        if (start) begin
          pending_nxt = reglist;
          addr_nxt    = base;
          state_nxt   = (reglist == '0) ? DONE : XFER;
        end
      end
      XFER: begin
        busy     = 1'b1;
        mem_addr = addr;
        if (ld_q) begin
          if (cur == 4'd15) begin
            pc_we = 1'b1;
            pc_wd = mem_rd;
          end else begin
            rf_we = 1'b1;
            rf_wa = cur;
            rf_wd = mem_rd;
          end
        end else begin
          rf_ra  = cur;
          mem_we = 1'b1;
          mem_wd = rf_rd;
        end
        pending_nxt[cur] = 1'b0;
        addr_nxt         = addr + 32'd4;
        if (last) state_nxt = wb_q ? WB : DONE;
      end
      WB: begin
        busy = 1'b1;
        if (rn_q == 4'd15) begin
          pc_we = 1'b1;
          pc_wd = addr;
        end else begin
          rf_we = 1'b1;
          rf_wa = rn_q;
          rf_wd = addr;
        end
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// Scoreboard bench for ldm_stm_sequencer: a list-level reference model queues cycle-stamped
// expected outputs; a monitor compares every cycle against the queue (idle cycles expect all zero).
`timescale 1ns/100ps
module tb_ldm_stm_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        is_load = 1'b0;
  logic        wb = 1'b0;
  logic [3:0]  rn = '0;
  logic [31:0] base = '0;
  logic [15:0] reglist = '0;
  logic        rf_we, pc_we, mem_we, busy, done;
  logic [3:0]  rf_wa, rf_ra;
  logic [31:0] rf_wd, pc_wd, mem_addr, mem_wd, rf_rd, mem_rd;

  always #5 clk = ~clk;

  ldm_stm_sequencer #(.N_REGS(16)) dut (
    .clk(clk), .rst(rst), .start(start), .is_load(is_load), .wb(wb), .rn(rn),
    .base(base), .reglist(reglist), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .rf_ra(rf_ra), .rf_rd(rf_rd), .pc_we(pc_we), .pc_wd(pc_wd), .mem_addr(mem_addr),
    .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy), .done(done)
  );

  typedef struct packed {
    logic        rf_we;
    logic [3:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [3:0]  rf_ra;
    logic        pc_we;
    logic [31:0] pc_wd;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wd;
    logic        busy;
    logic        done;
  } obs_t;

  typedef struct {
    int unsigned cyc;
    obs_t        v;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] rf_init(input int i);
    return (i == 0) ? 32'd5 : (i == 1) ? 32'd7 : 32'h1000_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] mem_init(input int i);
    return 32'hC0DE_0000 ^ (32'(i) * 32'h0001_0003);
  endfunction

  // Environment: register file and memory commit on negedge, read combinationally.
  logic [31:0] env_rf [0:15];
  logic [31:0] env_pc;
  logic [31:0] env_mem [0:255];
  bit          env_ready = 1'b0;

  always @(negedge clk) begin
    if (!env_ready) begin
      for (int i = 0; i < 16; i++) env_rf[i] <= rf_init(i);
      for (int i = 0; i < 256; i++) env_mem[i] <= mem_init(i);
      env_pc    <= 32'h40;
      env_ready <= 1'b1;
    end else begin
      if (rf_we) env_rf[rf_wa] <= rf_wd;
      if (pc_we) env_pc <= pc_wd;
      if (mem_we) env_mem[mem_addr[9:2]] <= mem_wd;
    end
  end

  assign rf_rd  = (rf_ra == 4'd15) ? env_pc : env_rf[rf_ra];
  assign mem_rd = env_mem[mem_addr[9:2]];

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor
  obs_t act, req;
  exp_t mon_e;
  always @(posedge clk) begin
    #1;
    act = {rf_we, rf_wa, rf_wd, rf_ra, pc_we, pc_wd, mem_addr, mem_we, mem_wd, busy, done};
    req = '0;
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      mon_e = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("FAIL missed_event: cycle %0d expectation %0h never presented", mon_e.cyc, mon_e.v);
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      mon_e = exp_q.pop_front();
      req   = mon_e.v;
    end
    check($sformatf("outputs@cyc%0d", cyc), act, req);
  end

  // Reference model: list-level view of the instruction.
  logic [31:0] ref_rf [0:15];
  logic [31:0] ref_pc;
  logic [31:0] ref_mem [0:255];

  task automatic model_op(input logic ld, input logic w, input logic [3:0] r,
                          input logic [31:0] b, input logic [15:0] list,
                          input int unsigned k, input int max_x, output int unsigned kd);
    int          n = 0;
    int          total;
    int          span;
    logic [31:0] a;
    obs_t        o;
    exp_t        e;
    total = $countones(list);
    for (int i = 0; i < 16; i++) begin
      if (!list[i]) continue;
      if (n == max_x) break;
      a = b + 32'(4 * n);
      o = '0;
      o.busy = 1'b1;
      o.mem_addr = a;
      if (ld) begin
        if (i == 15) begin
          o.pc_we = 1'b1; o.pc_wd = ref_mem[a[9:2]]; ref_pc = o.pc_wd;
        end else begin
          o.rf_we = 1'b1; o.rf_wa = 4'(i); o.rf_wd = ref_mem[a[9:2]]; ref_rf[i] = o.rf_wd;
        end
      end else begin
        o.rf_ra = 4'(i); o.mem_we = 1'b1;
        o.mem_wd = (i == 15) ? ref_pc : ref_rf[i];
        ref_mem[a[9:2]] = o.mem_wd;
      end
      e.cyc = k + n; e.v = o; exp_q.push_back(e);
      n++;
    end
    kd = k + 32'(n);
    if (n < total) return;   // transfer cut short by reset
    span = total;
    if (total != 0 && w && !(ld && list[r])) begin
      a = b + 32'(4 * total);
      o = '0;
      o.busy = 1'b1;
      if (r == 4'd15) begin
        o.pc_we = 1'b1; o.pc_wd = a; ref_pc = a;
      end else begin
        o.rf_we = 1'b1; o.rf_wa = r; o.rf_wd = a; ref_rf[r] = a;
      end
      e.cyc = k + 32'(total); e.v = o; exp_q.push_back(e);
      span = total + 1;
    end
    o = '0;
    o.done = 1'b1;
    e.cyc = k + 32'(span); e.v = o; exp_q.push_back(e);
    kd = k + 32'(span);
  endtask

  task automatic run_op(input logic ld, input logic w, input logic [3:0] r,
                        input logic [31:0] b, input logic [15:0] list, input bit noise);
    int unsigned k, kd;
    @(negedge clk);
    is_load = ld; wb = w; rn = r; base = b; reglist = list; start = 1'b1;
    k = cyc + 1;
    model_op(ld, w, r, b, list, k, 16, kd);
    while (cyc < kd) begin
      @(negedge clk);
      start = noise ? 1'($urandom) : 1'b0;
      if (noise) begin
        {is_load, wb} = 2'($urandom);
        rn      = 4'($urandom);
        base    = $urandom();
        reglist = 16'($urandom);
      end
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic reset_mid_xfer();
    int unsigned k, kd;
    @(negedge clk);
    is_load = 1'b1; wb = 1'b1; rn = 4'd9; base = 32'h300; reglist = 16'h00F0; start = 1'b1;
    k = cyc + 1;
    model_op(1'b1, 1'b1, 4'd9, 32'h300, 16'h00F0, k, 1, kd);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #0.5 rst = 1'b1;
    #0.1;
    check("rst_rf_we", rf_we, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_mem_addr", mem_addr, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 4; i <= 9; i++) check($sformatf("rst_r%0d", i), env_rf[i], ref_rf[i]);
  endtask

  initial begin
    logic [15:0] rl;
    for (int i = 0; i < 16; i++) ref_rf[i] = rf_init(i);
    for (int i = 0; i < 256; i++) ref_mem[i] = mem_init(i);
    ref_pc = 32'h40;

    rst = 1'b1;
    #1;
    check("reset_outputs",
          {rf_we, rf_wa, rf_wd, rf_ra, pc_we, pc_wd, mem_addr, mem_we, mem_wd, busy, done}, '0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle(1);

    // STM of r0, r1, PC
    run_op(1'b0, 1'b0, 4'd13, 32'h200, 16'h8003, 1'b0);
    check("stm_mem200", env_mem[128], 32'd5);
    check("stm_mem204", env_mem[129], 32'd7);
    check("stm_mem208", env_mem[130], 32'h40);

    // LDM r1,r2,r4 with writeback to r0
    run_op(1'b1, 1'b1, 4'd0, 32'h100, 16'h0016, 1'b0);
    check("ldm_r1", env_rf[1], mem_init(64));
    check("ldm_r2", env_rf[2], mem_init(65));
    check("ldm_r4", env_rf[4], mem_init(66));
    check("ldm_wb_r0", env_rf[0], 32'h10C);

    // Base register in a load list: loaded value wins, no writeback
    run_op(1'b1, 1'b1, 4'd2, 32'h180, 16'h0024, 1'b0);
    check("ldm_base_r2", env_rf[2], mem_init(96));

    // Load into PC across the 2^32 address wrap
    run_op(1'b1, 1'b0, 4'd3, 32'hFFFF_FFFC, 16'h8001, 1'b0);
    check("wrap_r0", env_rf[0], mem_init(255));
    check("wrap_pc", env_pc, mem_init(0));

    // Empty list with wb requested, and start noise during XFER/DONE
    run_op(1'b1, 1'b1, 4'd5, 32'h40, 16'h0000, 1'b1);
    run_op(1'b1, 1'b1, 4'd6, 32'h80, 16'h0F00, 1'b1);
    run_op(1'b0, 1'b1, 4'd15, 32'h3F0, 16'hA0A0, 1'b1);

    reset_mid_xfer();
    run_op(1'b1, 1'b1, 4'd10, 32'h3E0, 16'h000F, 1'b0);

    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 7))
        0:       rl = 16'h0000;
        1:       rl = 16'hFFFF;
        2:       rl = 16'h0001 << $urandom_range(0, 15);
        default: rl = 16'($urandom) & 16'($urandom);
      endcase
      run_op(1'($urandom), 1'($urandom), 4'($urandom), $urandom() & 32'hFFFF_FFFC, rl,
             1'($urandom));
    end
    idle(4);

    for (int i = 0; i < 15; i++) check($sformatf("final_r%0d", i), env_rf[i], ref_rf[i]);
    check("final_pc", env_pc, ref_pc);
    for (int i = 0; i < 256; i++) check($sformatf("final_mem%0d", i), env_mem[i], ref_mem[i]);
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL leftover_events: %0d expectations never presented", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
